// File: rtl/csidh_ise_pkg.sv
// Shared constants and op-select decode for the CSIDH-512 shift-add ISE datapath.
package csidh_ise_pkg;

  localparam int XLEN_DEFAULT = 64;

  // Limb width of the 512-bit reduced-radix rv64 layout.
  localparam int RADIX_BITS = 57;

  typedef enum logic [1:0] {
    OP_NONE    = 2'd0,
    OP_SRAIADD = 2'd1,
    OP_SRLIADD = 2'd2
  } op_sel_t;

  function automatic op_sel_t decode_op(input logic op_sra, input logic op_srl);
    op_sel_t sel;
    sel = OP_NONE;
    if (op_sra) begin
      sel = OP_SRAIADD;
    end else if (op_srl) begin
      sel = OP_SRLIADD;
    end
    return sel;
  endfunction

endpackage

// File: rtl/csidh_ise_sar.sv
// Combinational log2 barrel shifter (right shift) with arithmetic or zero fill.
module csidh_ise_sar #(
  parameter int XLEN = 64,
  localparam int SHW = $clog2(XLEN)
) (
  input  logic [XLEN-1:0] value,
  input  logic [SHW-1:0]  shamt,
  input  logic            logical,
  output logic [XLEN-1:0] result
);

  logic fill;

  assign fill = logical ? 1'b0 : value[XLEN-1];

  // Level gi shifts by 2^gi when shamt[gi] is set; levels chain LSB first.
  for (genvar gi = 0; gi < SHW; gi++) begin : g_level
    localparam int STEP = 1 << gi;
    logic [XLEN-1:0] stage_in;
    logic [XLEN-1:0] stage_out;

    if (gi == 0) begin : g_first
      assign stage_in = value;
    end else begin : g_chain
      assign stage_in = g_level[gi-1].stage_out;
    end

    assign stage_out = shamt[gi] ? {{STEP{fill}}, stage_in[XLEN-1:STEP]} : stage_in;
  end

  assign result = g_level[SHW-1].stage_out;

endmodule

// File: rtl/csidh_ise_shadd_pipe.sv
// Two-stage valid/ready pipeline computing rd = rs1 + (rs2 >> shamt).
// Logical-shift variant (srliadd) is built only when CSIDH_ISE_SRLIADD_EN is defined.
module csidh_ise_shadd_pipe
  import csidh_ise_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT,
  localparam int SHW = $clog2(XLEN)
) (
  input  logic            g_clk,
  input  logic            g_resetn,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_rs1,
  input  logic [XLEN-1:0] in_rs2,
  input  logic [SHW-1:0]  in_shamt,
  input  logic            in_op_sraiadd,
  input  logic            in_op_srliadd,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_rd
);

  op_sel_t         op_sel;
  logic            op_hit;
  logic            logical_fill;
  logic [XLEN-1:0] shifted;

  logic            s1_valid_reg;
  logic            s1_hit_reg;
  logic [XLEN-1:0] s1_rs1_reg;
  logic [XLEN-1:0] s1_shifted_reg;

  logic            out_valid_reg;
  logic [XLEN-1:0] out_rd_reg;
  logic [XLEN-1:0] rd_next;

  logic            s1_adv;
  logic            s2_adv;

`ifdef CSIDH_ISE_SRLIADD_EN
  assign op_sel       = decode_op(in_op_sraiadd, in_op_srliadd);
  assign logical_fill = (op_sel == OP_SRLIADD);
`else
  // srliadd is ignored: it decodes to OP_NONE and the fill bit stays arithmetic.
  logic srliadd_unused;
  assign srliadd_unused = in_op_srliadd;
  assign op_sel         = decode_op(in_op_sraiadd, 1'b0);
  assign logical_fill   = 1'b0;
`endif

  assign op_hit = (op_sel != OP_NONE);

  csidh_ise_sar #(
    .XLEN(XLEN)
  ) u_sar (
    .value  (in_rs2),
    .shamt  (in_shamt),
    .logical(logical_fill),
    .result (shifted)
  );

  // in_ready is the only combinational path and depends on out_ready alone.
  assign s2_adv   = !out_valid_reg || out_ready;
  assign s1_adv   = !s1_valid_reg || s2_adv;
  assign in_ready = s1_adv;

  always_ff @(posedge g_clk) begin
    if (!g_resetn) begin
      s1_valid_reg   <= 1'b0;
      s1_hit_reg     <= 1'b0;
      s1_rs1_reg     <= '0;
      s1_shifted_reg <= '0;
    end else if (s1_adv) begin
      s1_valid_reg   <= in_valid;
      s1_hit_reg     <= op_hit;
      s1_rs1_reg     <= in_rs1;
      s1_shifted_reg <= shifted;
    end
  end

  // Unmatched ops flow through with a zero result; carry out is discarded.
  assign rd_next = s1_hit_reg ? (s1_rs1_reg + s1_shifted_reg) : '0;

  always_ff @(posedge g_clk) begin
    if (!g_resetn) begin
      out_valid_reg <= 1'b0;
      out_rd_reg    <= '0;
    end else if (s2_adv) begin
      out_valid_reg <= s1_valid_reg;
      out_rd_reg    <= rd_next;
    end
  end

  assign out_valid = out_valid_reg;
  assign out_rd    = out_rd_reg;

endmodule

// File: tb/tb_csidh_ise_shadd_pipe.sv
// Self-checking bench for csidh_ise_shadd_pipe (64-bit and 32-bit instances).
module tb_csidh_ise_shadd_pipe;
  import csidh_ise_pkg::*;

`ifdef CSIDH_ISE_SRLIADD_EN
  localparam bit SRL_EN = 1'b1;
`else
  localparam bit SRL_EN = 1'b0;
`endif

  logic        g_clk = 1'b0;
  logic        g_resetn;
  logic        in_valid, in_ready, in_op_sraiadd, in_op_srliadd;
  logic [63:0] in_rs1, in_rs2, out_rd;
  logic [5:0]  in_shamt;
  logic        out_valid, out_ready;

  logic        h_in_valid, h_in_ready, h_in_op_sraiadd, h_in_op_srliadd;
  logic [31:0] h_in_rs1, h_in_rs2, h_out_rd;
  logic [4:0]  h_in_shamt;
  logic        h_out_valid, h_out_ready;

  int n_cmp = 0;
  int n_err = 0;
  int edge_cnt = 0;

  typedef struct {
    logic [63:0] rd;
    int          edge_no;
  } exp_t;
  exp_t q[$];

  csidh_ise_shadd_pipe #(.XLEN(64)) u_dut (
    .g_clk(g_clk), .g_resetn(g_resetn),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_shamt(in_shamt),
    .in_op_sraiadd(in_op_sraiadd), .in_op_srliadd(in_op_srliadd),
    .out_valid(out_valid), .out_ready(out_ready), .out_rd(out_rd)
  );

  csidh_ise_shadd_pipe #(.XLEN(32)) u_dut32 (
    .g_clk(g_clk), .g_resetn(g_resetn),
    .in_valid(h_in_valid), .in_ready(h_in_ready),
    .in_rs1(h_in_rs1), .in_rs2(h_in_rs2), .in_shamt(h_in_shamt),
    .in_op_sraiadd(h_in_op_sraiadd), .in_op_srliadd(h_in_op_srliadd),
    .out_valid(h_out_valid), .out_ready(h_out_ready), .out_rd(h_out_rd)
  );

  always #5 g_clk = ~g_clk;
  always @(posedge g_clk) edge_cnt <= edge_cnt + 1;

  // Reference: rd = rs1 + (rs2 >> sh) mod 2^w, zero when no op is honoured.
  function automatic logic [63:0] ref_rd(input int w, input logic [63:0] rs1,
                                         input logic [63:0] rs2, input int sh,
                                         input bit sra, input bit srl);
    longint signed sv;
    int signed     s32;
    logic [63:0]   sh_val;
    logic [63:0]   r;
    if (sra) begin
      if (w == 32) begin
        s32 = rs2[31:0];
        sv  = s32;
      end else begin
        sv = rs2;
      end
      sh_val = sv >>> sh;
    end else if (srl && SRL_EN) begin
      sh_val = (w == 32) ? ({32'd0, rs2[31:0]} >> sh) : (rs2 >> sh);
    end else begin
      return 64'd0;
    end
    r = rs1 + sh_val;
    if (w == 32) r = r & 64'h0000_0000_FFFF_FFFF;
    return r;
  endfunction

  task automatic idle();
    in_valid = 1'b0; in_op_sraiadd = 1'b0; in_op_srliadd = 1'b0;
    h_in_valid = 1'b0; h_in_op_sraiadd = 1'b0; h_in_op_srliadd = 1'b0;
  endtask

  task automatic send(input logic [63:0] rs1, input logic [63:0] rs2, input int sh,
                      input bit sra, input bit srl);
    in_valid = 1'b1; in_rs1 = rs1; in_rs2 = rs2; in_shamt = 6'(sh);
    in_op_sraiadd = sra; in_op_srliadd = srl;
  endtask

  task automatic test_reset();
    g_resetn = 1'b0;
    out_ready = 1'b1; h_out_ready = 1'b1;
    send(64'h1234, 64'h5678, 3, 1'b1, 1'b0);
    h_in_valid = 1'b1; h_in_rs1 = 32'h1; h_in_rs2 = 32'h2; h_in_shamt = 5'd0;
    h_in_op_sraiadd = 1'b1; h_in_op_srliadd = 1'b0;
    repeat (3) @(posedge g_clk);
    #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset out_valid: got %b want 0", out_valid); end
    n_cmp++; if (out_rd !== 64'd0) begin n_err++; $display("FAIL reset out_rd: got %h want 0", out_rd); end
    n_cmp++; if (h_out_valid !== 1'b0) begin n_err++; $display("FAIL reset out_valid32: got %b want 0", h_out_valid); end
    n_cmp++; if (h_out_rd !== 32'd0) begin n_err++; $display("FAIL reset out_rd32: got %h want 0", h_out_rd); end
    idle();
    g_resetn = 1'b1;
    #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset in_ready: got %b want 1", in_ready); end
    q.delete();
  endtask

  task automatic test_directed();
    logic [63:0] t_rs1 [6];
    logic [63:0] t_rs2 [6];
    int          t_sh  [6];
    bit          t_sra [6];
    bit          t_srl [6];
    logic [63:0] t_exp [6];
    t_rs1 = '{64'h1, 64'h10, 64'h7, 64'h0, 64'h0, 64'h5};
    t_rs2 = '{64'h8000_0000_0000_0000, 64'h0400_0000_0000_0000, 64'h9,
              64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 64'h3};
    t_sh  = '{63, RADIX_BITS, 0, 63, 63, 0};
    t_sra = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    t_srl = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    t_exp = '{64'h0, 64'h12, 64'h10, (SRL_EN ? 64'h1 : 64'h0),
              64'hFFFF_FFFF_FFFF_FFFF, 64'h0};
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      send(t_rs1[i], t_rs2[i], t_sh[i], t_sra[i], t_srl[i]);
      #1;
      n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL dir%0d in_ready: got %b want 1", i, in_ready); end
      @(posedge g_clk); #1;
      idle();
      n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL dir%0d early out_valid: got %b want 0", i, out_valid); end
      @(posedge g_clk); #1;
      n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL dir%0d out_valid: got %b want 1", i, out_valid); end
      n_cmp++; if (out_rd !== t_exp[i]) begin n_err++; $display("FAIL dir%0d out_rd: got %h want %h", i, out_rd, t_exp[i]); end
      $display("dir%0d rs1=%h rs2=%h sh=%0d sra=%0d srl=%0d rd=%h", i, t_rs1[i], t_rs2[i], t_sh[i], t_sra[i], t_srl[i], out_rd);
      @(posedge g_clk); #1;
      n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL dir%0d late out_valid: got %b want 0", i, out_valid); end
    end
  endtask

  task automatic test_back_to_back();
    int          ri = 0;
    logic [63:0] got[$];
    bit          saw_not_ready = 1'b0;
    bit          stalled_prev = 1'b0;
    logic [63:0] held_rd = '0;
    bit          acc, pop, exp_ready, exp_ov;
    for (int cyc = 1; cyc <= 14; cyc++) begin
      if (ri < 4) send(64'(ri), 64'(ri), 0, 1'b1, 1'b0);
      else idle();
      out_ready = !(cyc >= 3 && cyc <= 6);
      #1;
      exp_ready = (q.size() < 2) || out_ready;
      exp_ov    = (q.size() > 0) && (q[0].edge_no < edge_cnt);
      n_cmp++; if (in_ready !== exp_ready) begin n_err++; $display("FAIL b2b c%0d in_ready: got %b want %b", cyc, in_ready, exp_ready); end
      n_cmp++; if (out_valid !== exp_ov) begin n_err++; $display("FAIL b2b c%0d out_valid: got %b want %b", cyc, out_valid, exp_ov); end
      if (stalled_prev) begin
        n_cmp++; if (out_rd !== held_rd) begin n_err++; $display("FAIL b2b c%0d stall out_rd: got %h want %h", cyc, out_rd, held_rd); end
      end
      if (!in_ready) saw_not_ready = 1'b1;
      acc = in_valid && in_ready;
      pop = out_valid && out_ready;
      if (pop) begin
        got.push_back(out_rd);
        $display("b2b c%0d pop rd=%h", cyc, out_rd);
      end
      stalled_prev = out_valid && !out_ready;
      held_rd = out_rd;
      @(posedge g_clk); #1;
      if (pop && q.size() > 0) void'(q.pop_front());
      if (acc) begin
        q.push_back('{rd: 64'(2 * ri), edge_no: edge_cnt});
        ri++;
      end
    end
    idle(); out_ready = 1'b1;
    n_cmp++; if (got.size() != 4) begin n_err++; $display("FAIL b2b count: got %0d want 4", got.size()); end
    for (int i = 0; i < 4 && i < got.size(); i++) begin
      n_cmp++; if (got[i] !== 64'(2 * i)) begin n_err++; $display("FAIL b2b seq%0d: got %h want %h", i, got[i], 64'(2 * i)); end
    end
    n_cmp++; if (!saw_not_ready) begin n_err++; $display("FAIL b2b in_ready never low: got 0 want 1"); end
    q.delete();
  endtask

  task automatic test_xlen32();
    logic [31:0] rs1, rs2, exp_rd;
    int          sh;
    bit          sra, srl;
    h_out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      if (i == 0) begin
        rs1 = 32'hFFFF_FFFF; rs2 = 32'h2; sh = 1; sra = 1'b1; srl = 1'b0;
      end else begin
        rs1 = $urandom; rs2 = $urandom; sh = $urandom_range(0, 31);
        sra = 1'($urandom_range(0, 1)); srl = 1'($urandom_range(0, 1));
      end
      exp_rd = 32'(ref_rd(32, {32'd0, rs1}, {32'd0, rs2}, sh, sra, srl));
      if (i == 0) exp_rd = 32'h0;
      h_in_valid = 1'b1; h_in_rs1 = rs1; h_in_rs2 = rs2; h_in_shamt = 5'(sh);
      h_in_op_sraiadd = sra; h_in_op_srliadd = srl;
      @(posedge g_clk); #1;
      idle();
      @(posedge g_clk); #1;
      n_cmp++; if (h_out_valid !== 1'b1) begin n_err++; $display("FAIL x32_%0d out_valid: got %b want 1", i, h_out_valid); end
      n_cmp++; if (h_out_rd !== exp_rd) begin n_err++; $display("FAIL x32_%0d out_rd: got %h want %h", i, h_out_rd, exp_rd); end
      $display("x32_%0d rs1=%h rs2=%h sh=%0d sra=%0d srl=%0d rd=%h", i, rs1, rs2, sh, sra, srl, h_out_rd);
      @(posedge g_clk); #1;
    end
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b1;
    send(64'h11, 64'h22, 1, 1'b1, 1'b0);
    @(posedge g_clk); #1;
    send(64'h33, 64'h44, 2, 1'b1, 1'b0);
    @(posedge g_clk); #1;
    idle();
    g_resetn = 1'b0;
    @(posedge g_clk); #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rstmid out_valid: got %b want 0", out_valid); end
    n_cmp++; if (out_rd !== 64'd0) begin n_err++; $display("FAIL rstmid out_rd: got %h want 0", out_rd); end
    g_resetn = 1'b1;
    #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL rstmid in_ready: got %b want 1", in_ready); end
    for (int i = 0; i < 4; i++) begin
      @(posedge g_clk); #1;
      n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rstmid stale%0d out_valid: got %b want 0", i, out_valid); end
    end
    $display("rstmid done out_valid=%b out_rd=%h", out_valid, out_rd);
    q.delete();
  endtask

  task automatic test_random();
    bit          stalled_prev = 1'b0;
    logic [63:0] held_rd = '0;
    logic [63:0] exp_item;
    bit          acc, pop, exp_ready, exp_ov, sra, srl;
    int          sh, pops = 0;
    for (int cyc = 0; cyc < 412; cyc++) begin
      if (cyc < 400) begin
        sra = 1'($urandom_range(0, 3) != 0);
        srl = 1'($urandom_range(0, 1));
        case ($urandom_range(0, 3))
          0: sh = 0;
          1: sh = 63;
          2: sh = RADIX_BITS;
          default: sh = $urandom_range(0, 63);
        endcase
        send({$urandom, $urandom}, {$urandom, $urandom}, sh, sra, srl);
        in_valid = ($urandom_range(0, 3) != 0);
        out_ready = ($urandom_range(0, 2) != 0);
      end else begin
        idle(); out_ready = 1'b1;
      end
      exp_item = ref_rd(64, in_rs1, in_rs2, int'(in_shamt), in_op_sraiadd, in_op_srliadd);
      #1;
      exp_ready = (q.size() < 2) || out_ready;
      exp_ov    = (q.size() > 0) && (q[0].edge_no < edge_cnt);
      n_cmp++; if (in_ready !== exp_ready) begin n_err++; $display("FAIL rnd c%0d in_ready: got %b want %b", cyc, in_ready, exp_ready); end
      n_cmp++; if (out_valid !== exp_ov) begin n_err++; $display("FAIL rnd c%0d out_valid: got %b want %b", cyc, out_valid, exp_ov); end
      if (out_valid && exp_ov) begin
        n_cmp++; if (out_rd !== q[0].rd) begin n_err++; $display("FAIL rnd c%0d out_rd: got %h want %h", cyc, out_rd, q[0].rd); end
      end
      if (stalled_prev) begin
        n_cmp++; if (out_rd !== held_rd) begin n_err++; $display("FAIL rnd c%0d stall out_rd: got %h want %h", cyc, out_rd, held_rd); end
      end
      acc = in_valid && in_ready;
      pop = out_valid && out_ready;
      if (pop) begin
        pops++;
        $display("rnd c%0d pop rd=%h", cyc, out_rd);
      end
      stalled_prev = out_valid && !out_ready;
      held_rd = out_rd;
      @(posedge g_clk); #1;
      if (pop && q.size() > 0) void'(q.pop_front());
      if (acc) q.push_back('{rd: exp_item, edge_no: edge_cnt});
    end
    n_cmp++; if (q.size() != 0) begin n_err++; $display("FAIL rnd drain: got %0d left want 0", q.size()); end
    n_cmp++; if (pops == 0) begin n_err++; $display("FAIL rnd pops: got 0 want >0"); end
  endtask

  initial begin
    idle();
    in_rs1 = '0; in_rs2 = '0; in_shamt = '0;
    h_in_rs1 = '0; h_in_rs2 = '0; h_in_shamt = '0;
    out_ready = 1'b1; h_out_ready = 1'b1;
    test_reset();
    test_directed();
    test_back_to_back();
    test_xlen32();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
